iter_shifter32: RTL and testbench



---
 rtl/iter_shifter32_if.sv | 24 ++
 rtl/iter_shifter32.sv | 92 +++++++++
 tb/tb_iter_shifter32.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/iter_shifter32_if.sv
// Start/busy/done handshake and operand bus between ALU control
// and the iterative shifter.
interface iter_shifter32_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [1:0]       op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic             busy;
    logic             done;

    modport master (
        output start, op, shamt, d_in,
        input  d_out, busy, done
    );

    modport slave (
        input  start, op, shamt, d_in,
        output d_out, busy, done
    );
endinterface

// File: rtl/iter_shifter32.sv
// Multi-cycle 32-bit shifter issuing steps of at most 3 positions.
// Define ITER_SHIFTER_ROTATE_EN to make op=11 a rotate right.
module iter_shifter32 #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    iter_shifter32_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       step;

    // One 2-bit step, identical to the downstream 4:1-mux shift unit
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [1:0]       o,
        input logic [WIDTH-1:0] v,
        input logic [1:0]       k
    );
        logic [WIDTH+2:0] ext;
        logic [WIDTH-1:0] r;
        ext = {3'b000, v};
        unique case (o)
            2'b10: ext = {{3{v[WIDTH-1]}}, v};
`ifdef ITER_SHIFTER_ROTATE_EN
            2'b11: ext = {v[2:0], v};
`endif
            default: ext = {3'b000, v};
        endcase
        if (o == 2'b00) begin
            r = v << k;
        end else begin
            r = WIDTH'(ext >> k);
        end
        return r;
    endfunction

    assign step = (rem_q > SHW'(3)) ? 2'd3 : rem_q[1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dout_q  <= '0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dout_q  <= dout_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dout_d  = dout_q;
        op_d    = op_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    rem_d   = bus.shamt;
                    dout_d  = bus.d_in;
                    state_d = (bus.shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                dout_d = step_fn(op_q, dout_q, step);
                rem_d  = rem_q - SHW'(step);
                if (rem_q <= SHW'(3)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.d_out = dout_q;
    assign bus.busy  = (state_q == SHIFT);
    assign bus.done  = (state_q == DONE);
endmodule

// File: tb/tb_iter_shifter32.sv
// Directed and random checks of iter_shifter32 against a
// whole-shift reference model.
module tb_iter_shifter32;
    logic clk = 1'b0;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    iter_shifter32_if #(.WIDTH(32), .SHW(5)) bus ();

    iter_shifter32 #(.WIDTH(32), .SHW(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op,
                                              input int s,
                                              input logic [31:0] d);
        logic signed [31:0] sd;
        sd = d;
        case (op)
            2'b00: return d << s;
            2'b01: return d >> s;
            2'b10: return sd >>> s;
            default: begin
`ifdef ITER_SHIFTER_ROTATE_EN
                if (s == 0) return d;
                return (d >> s) | (d << (32 - s));
`else
                return d >> s;
`endif
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // poke: edge index (1-based after E0) at which a stray start is
    // driven; poke_done drives start during the DONE cycle.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input int s, input logic [31:0] d,
                          input int poke, input bit poke_done);
        int edges;
        int busy_n;
        int exp_edges;
        logic [31:0] exp_val;
        exp_val   = ref_shift(op, s, d);
        exp_edges = 1 + (s + 2) / 3;
        bus.start = 1'b1;
        bus.op    = op;
        bus.shamt = 5'(s);
        bus.d_in  = d;
        tick();
        edges  = 1;
        busy_n = 0;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.shamt = 5'($urandom);
        bus.d_in  = $urandom;
        while (!bus.done && edges < 40) begin
            if (bus.busy) busy_n++;
            if (edges == poke) begin
                bus.start = 1'b1;
                bus.d_in  = 32'hFFFF_FFFF;
                bus.shamt = 5'd5;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            edges++;
        end
        chk({tag, ":done_seen"}, 32'(bus.done), 32'd1);
        chk({tag, ":edges"}, 32'(edges), 32'(exp_edges));
        chk({tag, ":busy_cycles"}, 32'(busy_n), 32'((s + 2) / 3));
        chk({tag, ":d_out"}, bus.d_out, exp_val);
        bus.start = poke_done;
        bus.shamt = 5'd5;
        tick();
        bus.start = 1'b0;
        chk({tag, ":done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, ":idle_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, ":hold"}, bus.d_out, exp_val);
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.shamt = 5'd3;
        bus.d_in  = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("rst:d_out", bus.d_out, 32'h0);
        chk("rst:busy", 32'(bus.busy), 32'd0);
        chk("rst:done", 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        reset_n   = 1'b1;
        tick();
        chk("rst:no_start", 32'(bus.busy), 32'd0);

        run_op("lsr31", 2'b01, 31, 32'h8000_0000, 0, 1'b0);
        chk("lsr31:val", bus.d_out, 32'h0000_0001);
        run_op("asr4", 2'b10, 4, 32'h8000_0000, 0, 1'b0);
        chk("asr4:val", bus.d_out, 32'hF800_0000);
        run_op("lsl0", 2'b00, 0, 32'h0000_0001, 0, 1'b1);
        chk("lsl0:val", bus.d_out, 32'h0000_0001);
        run_op("lsl5", 2'b00, 5, 32'h0000_0001, 0, 1'b0);
        chk("lsl5:val", bus.d_out, 32'h0000_0020);
        run_op("lsl9poke", 2'b00, 9, 32'h0000_000F, 2, 1'b1);
        chk("lsl9poke:val", bus.d_out, 32'h0000_1E00);

        run_op("ror1", 2'b11, 1, 32'h0000_0001, 0, 1'b0);
`ifdef ITER_SHIFTER_ROTATE_EN
        chk("ror1:val", bus.d_out, 32'h8000_0000);
`else
        chk("ror1:val", bus.d_out, 32'h0000_0000);
`endif

        bus.op    = 2'b00;
        bus.shamt = 5'd31;
        bus.d_in  = 32'h1234_5678;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("mid:busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        tick();
        chk("mid_rst:d_out", bus.d_out, 32'h0);
        chk("mid_rst:busy", 32'(bus.busy), 32'd0);
        chk("mid_rst:done", 32'(bus.done), 32'd0);
        reset_n = 1'b1;
        tick();
        tick();
        chk("mid_rst:idle", 32'(bus.busy | bus.done), 32'd0);

        for (int i = 0; i < 24; i++) begin
            run_op("rand", 2'($urandom), int'($urandom_range(0, 31)),
                   $urandom, 0, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
